// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between the framebuffer fetch engine and the VGA timing/DAC stage.
// Define VGA_PIXEL_FIFO_BLANK_EN to emit black pixels on underflow reads instead of dropping them.
module vga_pixel_fifo #(
  parameter int unsigned PIXEL_WIDTH     = 12,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned AFULL_THRESHOLD = 768,
  parameter int unsigned FRAME_CNT_WIDTH = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       enable_video_i,
  input  logic [FRAME_CNT_WIDTH-1:0] frame_pixels_i,
  input  logic                       write_i,
  input  logic [PIXEL_WIDTH-1:0]     pixel_i,
  output logic                       full_o,
  output logic                       almost_full_o,
  input  logic                       read_i,
  output logic [PIXEL_WIDTH-1:0]     pixel_o,
  output logic                       valid_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       end_of_frame_o,
  input  logic                       clear_errors_i,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  localparam logic [LVL_W-1:0]           LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]           LVL_AFULL = LVL_W'(AFULL_THRESHOLD);
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = FRAME_CNT_WIDTH'(1);

  logic [PIXEL_WIDTH-1:0]     mem [DEPTH];

  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_len_q, frame_len_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [PIXEL_WIDTH-1:0]     pixel_q, pixel_d;
  logic                       valid_q, valid_d;
  logic                       eof_q, eof_d;
  logic                       ovf_q, ovf_d;
  logic                       udf_q, udf_d;

  logic full, empty;
  logic wr_acc, rd_acc;
  logic ovf_set, udf_set;
  logic advance;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  // Acceptance and error detection all use the flags as they stood at cycle start.
  assign wr_acc  = write_i & ~full  & enable_video_i;
  assign rd_acc  = read_i  & ~empty & enable_video_i;
  assign ovf_set = write_i & full   & enable_video_i;
  assign udf_set = read_i  & empty  & enable_video_i;

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= pixel_i;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_len_d = frame_len_q;
    frame_cnt_d = frame_cnt_q;
    pixel_d     = pixel_q;
    valid_d     = 1'b0;
    eof_d       = 1'b0;
    advance     = 1'b0;

    if (!enable_video_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      frame_cnt_d = '0;
      frame_len_d = frame_pixels_i;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        pixel_d  = mem[rd_ptr_q];
        valid_d  = 1'b1;
        advance  = 1'b1;
      end
`ifdef VGA_PIXEL_FIFO_BLANK_EN
      else if (udf_set) begin
        // Underflow still produces a (black) pixel so raster timing never slips.
        pixel_d = '0;
        valid_d = 1'b1;
        advance = 1'b1;
      end
`endif

      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase

      // Frame lengths of 0 or 1 mark every pixel as end of frame.
      if (advance) begin
        if ((frame_len_q <= FRAME_ONE) || (frame_cnt_q == frame_len_q - FRAME_ONE)) begin
          eof_d       = 1'b1;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + FRAME_ONE;
        end
      end
    end

    ovf_d = ovf_set | (ovf_q & ~clear_errors_i);
    udf_d = udf_set | (udf_q & ~clear_errors_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_len_q <= '0;
      frame_cnt_q <= '0;
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_len_q <= frame_len_d;
      frame_cnt_q <= frame_cnt_d;
      pixel_q     <= pixel_d;
      valid_q     <= valid_d;
      eof_q       <= eof_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign full_o         = full;
  assign almost_full_o  = (level_q >= LVL_AFULL);
  assign empty_o        = empty;
  assign level_o        = level_q;
  assign pixel_o        = pixel_q;
  assign valid_o        = valid_q;
  assign end_of_frame_o = eof_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: directed and random steps checked against a queue-based model.
module tb_vga_pixel_fifo;

  localparam int unsigned PW    = 12;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AFT   = 768;
  localparam int unsigned FW    = 20;
  localparam int unsigned LW    = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [FW-1:0] frame_pixels;
  logic          write;
  logic [PW-1:0] pixel_in;
  logic          full, almost_full;
  logic          read;
  logic [PW-1:0] pixel_out;
  logic          valid, empty;
  logic [LW-1:0] level;
  logic          eof;
  logic          clear;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  vga_pixel_fifo #(
    .PIXEL_WIDTH(PW),
    .DEPTH(DEPTH),
    .AFULL_THRESHOLD(AFT),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .enable_video_i(enable),
    .frame_pixels_i(frame_pixels),
    .write_i(write),
    .pixel_i(pixel_in),
    .full_o(full),
    .almost_full_o(almost_full),
    .read_i(read),
    .pixel_o(pixel_out),
    .valid_o(valid),
    .empty_o(empty),
    .level_o(level),
    .end_of_frame_o(eof),
    .clear_errors_i(clear),
    .overflow_o(overflow),
    .underflow_o(underflow)
  );

  // Reference model: queue holds buffered pixels; m_n counts pixels emitted since last flush.
  logic [PW-1:0] mq[$];
  int unsigned   m_len;
  int unsigned   m_n;
  logic          m_valid, m_eof, m_ovf, m_udf;
  logic [PW-1:0] m_pix;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_len   = 0;
    m_n     = 0;
    m_valid = 1'b0;
    m_eof   = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_pix   = '0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":level"}, 32'(level), mq.size());
    chk({ph, ":full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({ph, ":afull"}, 32'(almost_full), 32'(mq.size() >= AFT));
    chk({ph, ":empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({ph, ":valid"}, 32'(valid), 32'(m_valid));
    chk({ph, ":eof"}, 32'(eof), 32'(m_eof));
    chk({ph, ":pixel"}, 32'(pixel_out), 32'(m_pix));
    chk({ph, ":ovf"}, 32'(overflow), 32'(m_ovf));
    chk({ph, ":udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic step(input string ph, input logic en, input logic wr, input logic [PW-1:0] px,
                      input logic rd, input logic clr, input logic [FW-1:0] fp);
    bit was_full, was_empty, adv;
    enable       = en;
    write        = wr;
    pixel_in     = px;
    read         = rd;
    clear        = clr;
    frame_pixels = fp;
    was_full     = (mq.size() == DEPTH);
    was_empty    = (mq.size() == 0);
    @(posedge clk);
    #1;
    adv     = 1'b0;
    m_valid = 1'b0;
    m_eof   = 1'b0;
    if (!en) begin
      mq.delete();
      m_len = fp;
      m_n   = 0;
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (wr && was_full) m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      if (rd && !was_empty) begin
        m_pix   = mq.pop_front();
        m_valid = 1'b1;
        adv     = 1'b1;
      end
`ifdef VGA_PIXEL_FIFO_BLANK_EN
      else if (rd) begin
        m_pix   = '0;
        m_valid = 1'b1;
        adv     = 1'b1;
      end
`endif
      if (wr && !was_full) mq.push_back(px);
      if (adv) begin
        m_n++;
        m_eof = (m_len <= 1) || ((m_n % m_len) == 0);
      end
    end
    check_all(ph);
  endtask

  initial begin
    int          vc;
    int unsigned eof_pos[$];
    bit          wr_r, rd_r, en_r;

    rst_n        = 1'b0;
    enable       = 1'b0;
    write        = 1'b0;
    read         = 1'b0;
    clear        = 1'b0;
    pixel_in     = '0;
    frame_pixels = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Basic round trip of 0x001..0x00A.
    for (int i = 1; i <= 10; i++) step("wr10", 1, 1, PW'(i), 0, 0, '0);
    chk("wr10:level10", 32'(level), 32'd10);
    for (int i = 1; i <= 10; i++) begin
      step("rd10", 1, 0, '0, 1, 0, '0);
      chk("rd10:data", 32'(pixel_out), 32'(i));
    end
    step("rd10_idle", 1, 0, '0, 0, 0, '0);
    chk("rd10:empty_end", 32'(empty), 32'd1);

    // Fill to full, overflow, read+write on full.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 1, PW'($urandom), 0, 0, '0);
    chk("fill:full", 32'(full), 32'd1);
    chk("fill:afull", 32'(almost_full), 32'd1);
    step("ovf", 1, 1, 12'hFFF, 0, 0, '0);
    chk("ovf:flag", 32'(overflow), 32'd1);
    chk("ovf:level", 32'(level), 32'd1024);
    step("full_rw", 1, 1, 12'h0AB, 1, 0, '0);
    chk("full_rw:level", 32'(level), 32'd1023);
    step("clr", 1, 0, '0, 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1, 0, '0, 1, 0, '0);
    step("clr2", 1, 0, '0, 0, 1, '0);

    // Read on empty with simultaneous write.
    step("empty_rw", 1, 1, 12'h5A5, 1, 0, '0);
    chk("empty_rw:level", 32'(level), 32'd1);
    chk("empty_rw:udf", 32'(underflow), 32'd1);
`ifdef VGA_PIXEL_FIFO_BLANK_EN
    chk("empty_rw:valid", 32'(valid), 32'd1);
    chk("empty_rw:black", 32'(pixel_out), 32'd0);
`else
    chk("empty_rw:valid", 32'(valid), 32'd0);
`endif
    step("pop5a5", 1, 0, '0, 1, 0, '0);
    chk("pop5a5:data", 32'(pixel_out), 32'h5A5);

    // Sticky set wins over clear in the same cycle; clear alone then clears.
    step("set_clr", 1, 0, '0, 1, 1, '0);
    chk("set_clr:udf", 32'(underflow), 32'd1);
    step("clr_only", 1, 0, '0, 0, 1, '0);
    chk("clr_only:udf", 32'(underflow), 32'd0);

    // Frame of 16 pixels, 40 streamed.
    step("flush16", 0, 0, '0, 0, 0, FW'(16));
    vc = 0;
    for (int i = 0; i <= 40; i++) begin
      step("frame", 1, (i < 40), PW'(i + 100), (i >= 1), 0, '0);
      if (valid) begin
        vc++;
        if (eof) eof_pos.push_back(vc);
      end
    end
    chk("frame:valid_cnt", 32'(vc), 32'd40);
    chk("frame:eof_cnt", 32'(eof_pos.size()), 32'd2);
    if (eof_pos.size() == 2) begin
      chk("frame:eof_first", eof_pos[0], 32'd16);
      chk("frame:eof_second", eof_pos[1], 32'd32);
    end

    // Mid-stream flush with level 50; sticky flags survive.
    step("udf_set", 1, 0, '0, 1, 0, '0);
    for (int i = 0; i < 50; i++) step("lvl50", 1, 1, PW'($urandom), 0, 0, '0);
    chk("lvl50:level", 32'(level), 32'd50);
    step("flush_mid", 0, 1, 12'h777, 1, 0, FW'(16));
    chk("flush_mid:level", 32'(level), 32'd0);
    chk("flush_mid:valid", 32'(valid), 32'd0);
    chk("flush_mid:udf", 32'(underflow), 32'd1);
    step("rt_wr", 1, 1, 12'h123, 0, 0, '0);
    step("rt_rd", 1, 0, '0, 1, 0, '0);
    chk("rt:data", 32'(pixel_out), 32'h123);

    // Random traffic with occasional flushes and clears.
    for (int i = 0; i < 3000; i++) begin
      en_r = ($urandom % 64) != 0;
      if (i < 1500) begin
        wr_r = ($urandom % 4) != 0;
        rd_r = ($urandom % 4) == 0;
      end else begin
        wr_r = ($urandom % 4) == 0;
        rd_r = ($urandom % 4) != 0;
      end
      step("rand", en_r, wr_r, PW'($urandom), rd_r, (($urandom % 16) == 0),
           FW'($urandom_range(0, 20)));
    end

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) step("pre_arst", 1, 1, PW'($urandom), 1, 0, '0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_arst", 1, 1, 12'h321, 0, 0, '0);
    step("post_arst_rd", 1, 0, '0, 1, 0, '0);
    chk("post_arst:data", 32'(pixel_out), 32'h321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
